// File: rtl/snn_pkg.sv
// snn_pkg: shared encoder FSM states and Galois LFSR constants/step function.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_GAP
    } state_t;

    localparam logic [23:0] LFSR_MASK    = 24'hE10000;
    localparam logic [23:0] DEFAULT_SEED = 24'hACE15B;

    function automatic logic [23:0] lfsr_step(input logic [23:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr24_galois.sv
// lfsr24_galois: 24-bit right-shifting Galois LFSR, x^24+x^23+x^22+x^17+1, advancing only when en is high.
module lfsr24_galois
    import snn_pkg::*;
#(
    parameter logic [23:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [23:0] q
);

    // An all-zero state would lock the LFSR up, so a zero seed is replaced by 1.
    localparam logic [23:0] SEED_NZ = (SEED == 24'h0) ? 24'h000001 : SEED;

    logic [23:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_q <= SEED_NZ;
        else if (en)
            r_q <= lfsr_step(r_q);
    end

    assign q = r_q;

endmodule

// File: rtl/spike_rate_encoder_3ch.sv
// spike_rate_encoder_3ch: Bernoulli rate coder turning three 8-bit intensities into spike trains
// over a WINDOW-cycle presentation, followed by a silent gap so the neuron can relax.
module spike_rate_encoder_3ch
    import snn_pkg::*;
#(
    parameter int          WINDOW     = 64,
    parameter int          GAP_CYCLES = 4,
    parameter logic [23:0] SEED       = DEFAULT_SEED,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       level0,
    input  logic [7:0]       level1,
    input  logic [7:0]       level2,
    input  logic             abort,
    output logic             x0,
    output logic             x1,
    output logic             x2,
    output logic             spike_valid,
    output logic             busy,
    output logic             window_done,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t                  r_state;
    logic [2:0][7:0]         r_lev;
    logic [2:0][CNT_W-1:0]   r_acc;
    logic [2:0][CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]        r_win;
    logic [GAP_W-1:0]        r_gap;
    logic [2:0]              r_x;
    logic                    r_sv;
    logic                    r_done;
    logic [23:0]             w_lfsr;
    logic [2:0]              w_spk;
    logic                    w_lfsr_en;

    // The LFSR freezes on an aborting edge so the next sample resumes from the same state.
    assign w_lfsr_en = (r_state == ST_ENCODE) && !abort;

    lfsr24_galois #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (w_lfsr_en),
        .q     (w_lfsr)
    );

    for (genvar k = 0; k < 3; k++) begin : g_cmp
        assign w_spk[k] = w_lfsr[8*k +: 8] < r_lev[k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_lev   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_win   <= '0;
            r_gap   <= '0;
            r_x     <= '0;
            r_sv    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_x  <= '0;
                    r_sv <= 1'b0;
                    if (in_valid) begin
                        r_lev   <= {level2, level1, level0};
                        r_acc   <= '0;
                        r_win   <= CNT_W'(WINDOW - 1);
                        r_state <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    if (abort) begin
                        r_x     <= '0;
                        r_sv    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_x  <= w_spk;
                        r_sv <= 1'b1;
                        for (int i = 0; i < 3; i++)
                            r_acc[i] <= r_acc[i] + CNT_W'(w_spk[i]);
                        if (r_win == '0) begin
                            r_done <= 1'b1;
                            for (int i = 0; i < 3; i++)
                                r_cnt[i] <= r_acc[i] + CNT_W'(w_spk[i]);
                            r_gap   <= GAP_W'(GAP_CYCLES - 1);
                            r_state <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                        end else begin
                            r_win <= r_win - 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    r_x     <= '0;
                    r_sv    <= 1'b0;
                    r_gap   <= r_gap - 1'b1;
                    r_state <= (abort || r_gap == '0) ? ST_IDLE : ST_GAP;
                end
                default: begin
                    r_x     <= '0;
                    r_sv    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign x0          = r_x[0];
    assign x1          = r_x[1];
    assign x2          = r_x[2];
    assign spike_valid = r_sv;
    assign window_done = r_done;
    assign count0      = r_cnt[0];
    assign count1      = r_cnt[1];
    assign count2      = r_cnt[2];

endmodule

// File: tb/tb_spike_rate_encoder_3ch.sv
// tb_spike_rate_encoder_3ch: scoreboard bench; a reference Galois LFSR predicts every spike
// and window count, which a negedge monitor compares against the encoder outputs.
module tb_spike_rate_encoder_3ch;

    localparam int          WIN  = 64;
    localparam int          GAP  = 4;
    localparam logic [23:0] SEED = 24'hACE15B;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] level0, level1, level2;
    logic       abort;
    logic       x0, x1, x2;
    logic       spike_valid;
    logic       busy;
    logic       window_done;
    logic [7:0] count0, count1, count2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          hs[$];
    logic [2:0]  q_x[$];
    logic [23:0] q_c[$];
    logic [23:0] m_lfsr = SEED;
    logic [23:0] lst    = '0;
    logic [2:0]  mon_x;
    logic [23:0] mon_c;

    spike_rate_encoder_3ch #(
        .WINDOW     (WIN),
        .GAP_CYCLES (GAP),
        .SEED       (SEED),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .level0      (level0),
        .level1      (level1),
        .level2      (level2),
        .abort       (abort),
        .x0          (x0),
        .x1          (x1),
        .x2          (x2),
        .spike_valid (spike_valid),
        .busy        (busy),
        .window_done (window_done),
        .count0      (count0),
        .count1      (count1),
        .count2      (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] nxt(input logic [23:0] s);
        return s[0] ? ((s >> 1) ^ 24'hE10000) : (s >> 1);
    endfunction

    // Predict one sample: spikes for each emitting cycle, and the counts if the window completes.
    task automatic push_sample(input logic [7:0] l0, l1, l2, input int stop);
        int c0 = 0, c1 = 0, c2 = 0;
        logic [2:0] e;
        for (int c = 0; c < WIN; c++) begin
            if (c == stop) break;
            e = {m_lfsr[23:16] < l2, m_lfsr[15:8] < l1, m_lfsr[7:0] < l0};
            q_x.push_back(e);
            c0 += int'(e[0]);
            c1 += int'(e[1]);
            c2 += int'(e[2]);
            m_lfsr = nxt(m_lfsr);
        end
        if (stop < 0) begin
            lst = {8'(c2), 8'(c1), 8'(c0)};
            q_c.push_back(lst);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] l0, l1, l2, input int stop, input bit hold);
        wait_ready();
        level0   = l0;
        level1   = l1;
        level2   = l2;
        in_valid = 1'b1;
        push_sample(l0, l1, l2, stop);
        @(negedge clk);
        abort = 1'b0;
        if (!hold) in_valid = 1'b0;
        if (stop >= 0) begin
            repeat (stop) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset && in_valid && in_ready) hs.push_back(cyc);
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (spike_valid) begin
                if (q_x.size() == 0) begin
                    check("spike_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_x = q_x.pop_front();
                    check("spikes", {29'd0, x2, x1, x0}, {29'd0, mon_x});
                end
            end else begin
                check("silent", {29'd0, x2, x1, x0}, 32'd0);
            end
            if (window_done) begin
                if (q_c.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_c = q_c.pop_front();
                    check("counts", {8'd0, count2, count1, count0}, {8'd0, mon_c});
                end
            end
        end
    end

    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        abort    = 1'b0;
        level0   = '0;
        level1   = '0;
        level2   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sv", {31'd0, spike_valid}, 32'd0);
        check("rst_done", {31'd0, window_done}, 32'd0);
        check("rst_cnt", {8'd0, count2, count1, count0}, 32'd0);
        reset = 1'b0;

        send(8'd255, 8'd128, 8'd1, -1, 1'b0);
        wait_ready();
        check("cnt0_high", {31'd0, count0 >= 8'd60}, 32'd1);
        check("cnt2_low", {31'd0, count2 <= 8'd3}, 32'd1);

        send(8'd0, 8'd0, 8'd0, -1, 1'b0);
        check("busy_enc", {31'd0, busy}, 32'd1);
        check("ready_enc", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!window_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_latency", n, WIN);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_latency", n, GAP);

        hs.delete();
        send(8'd255, 8'd128, 8'd1, -1, 1'b1);
        send(8'd40, 8'd200, 8'd90, -1, 1'b1);
        in_valid = 1'b0;
        check("hs_count", hs.size(), 32'd2);
        check("hs_spacing", (hs.size() >= 2) ? hs[1] - hs[0] : 0, WIN + GAP + 1);
        wait_ready();

        send(8'd100, 8'd150, 8'd50, 20, 1'b0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_keep_cnt", {8'd0, count2, count1, count0}, {8'd0, lst});
        abort = 1'b1;
        send(8'd255, 8'd128, 8'd1, -1, 1'b0);
        check("abort_idle_accept", {31'd0, busy}, 32'd1);
        wait_ready();

        send(8'd60, 8'd180, 8'd20, -1, 1'b0);
        repeat (10) begin
            @(negedge clk);
            level0   = 8'($urandom);
            level1   = 8'($urandom);
            level2   = 8'($urandom);
            in_valid = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        wait_ready();

        send(8'd255, 8'd128, 8'd1, -1, 1'b0);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_x", {29'd0, x2, x1, x0}, 32'd0);
        check("mid_rst_sv", {31'd0, spike_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_cnt", {8'd0, count2, count1, count0}, 32'd0);
        q_x.delete();
        q_c.delete();
        m_lfsr = SEED;
        lst    = '0;
        @(negedge clk);
        reset = 1'b0;
        send(8'd255, 8'd128, 8'd1, -1, 1'b0);
        wait_ready();

        repeat (4) @(negedge clk);
        check("spike_q_empty", q_x.size(), 32'd0);
        check("count_q_empty", q_c.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
